pwm_duty_ramp: RTL
==================

PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

Interface
REQ-001 SHALL have parameter TICK_DIV, default 256, giving the number of clk cycles between ramp steps (legal range 2..65535).
REQ-002 SHALL have parameter TICK_W, default 16, giving the width of the tick prescaler counter (must hold TICK_DIV-1).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port target_duty, input, 8 bits: requested duty from the SPI register bank, synchronous to clk.
REQ-006 SHALL have port ramp_en, input, 1 bit: 1 = ramp toward the target, 0 = bypass.
REQ-007 SHALL have port step, input, 4 bits: duty increment per tick; a value of 0 is treated as 1.
REQ-008 SHALL have port pwm_duty_cycle, output, 8 bits, registered: duty delivered to pwm_peripheral.
REQ-009 SHALL have port busy, output, 1 bit, registered: high while in RAMP_UP or RAMP_DOWN.
REQ-010 SHALL have port done, output, 1 bit, registered: one-cycle pulse when a ramp completes.

Function
REQ-011 SHALL implement a state machine with states IDLE, RAMP_UP and RAMP_DOWN.
REQ-012 In every state with ramp_en=0: next cycle pwm_duty_cycle=target_duty, state=IDLE, prescaler=0, busy=0, done=0.
REQ-013 In IDLE with ramp_en=1: go to RAMP_UP if target_duty>pwm_duty_cycle, go to RAMP_DOWN if it is lower, otherwise stay in IDLE; the prescaler is cleared on entry.
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 and wrap, only while in a RAMP state; a tick is the cycle where the count equals TICK_DIV-1.
REQ-015 The first duty change SHALL occur TICK_DIV cycles after entering a RAMP state, and every TICK_DIV cycles after that.
REQ-016 On a tick in RAMP_UP: duty=min(duty+step, target_duty), computed in 9 bits; no wrap past 255.
REQ-017 On a tick in RAMP_DOWN: duty=max(duty-step, target_duty), computed in 9 bits with a signed compare; no wrap below 0.
REQ-018 When the updated duty equals target_duty: next state=IDLE, and done=1 for exactly the one cycle in which the new duty is first visible.
REQ-019 Target change mid-ramp: re-evaluated every cycle without clearing the prescaler.
  - If target_duty equals the current duty: go to IDLE with a done pulse.
  - If the direction reverses: switch to the opposite RAMP state.
REQ-020 ramp_en falling mid-ramp SHALL follow REQ-012 and SHALL NOT pulse done.
REQ-021 pwm_duty_cycle SHALL change by at most max(step,1) per tick while ramp_en=1, and never overshoot target_duty.
REQ-022 busy SHALL be 0 in the same cycle done is 1.

Reset
REQ-023 While rst_n=0, asynchronously and regardless of clk: pwm_duty_cycle=0x00, state=IDLE, prescaler=0, busy=0, done=0.
REQ-024 After rst_n deasserts, the first active clk edge SHALL evaluate REQ-012/REQ-013 normally.

Structure
REQ-025 Shared package pwm_pkg SHALL hold the state enum type (IDLE/RAMP_UP/RAMP_DOWN) and constant DUTY_W=8, reused by pwm_peripheral and the SPI register bank.
REQ-026 The prescaler SHALL be one sub-module, ramp_tick_gen, with inputs clk, rst_n, clear and run, and output tick.
REQ-027 The top level SHALL insert pwm_duty_ramp between the SPI register bank's duty output and pwm_peripheral's duty input.
REQ-028 Target size: 120-400 lines of RTL.

Verification (TICK_DIV=4)
REQ-029 Reset: assert rst_n=0 mid-clock with duty=0x80 -> pwm_duty_cycle=0, busy=0, done=0 immediately, before the next edge.
REQ-030 Ramp up: ramp_en=1, step=1, target 0->4 -> duty reads 1,2,3,4 at 4-cycle intervals starting 4 cycles after entering RAMP_UP, with a single done pulse together with 4, then busy=0.
REQ-031 Clamp: step=15, target 0->20 -> duty 15 then 20 (not 30), done once.
REQ-032 Ramp down without wrap: start 255, step=8, target 0 -> duty 247, 239, ... 7, 0, ends at 0, done once.
REQ-033 Reversal and bypass:
  - Ramp up toward 100; at duty=30 set target=10 -> state RAMP_DOWN, duty decreases to 10.
  - Then drop ramp_en=0 with target 0xA5 -> duty=0xA5 after one clk, no done pulse.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty path: duty width, step width,
// ramp state type and the step-normalisation helper.
package pwm_pkg;

    localparam int DUTY_W = 8;
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } pwm_state_e;

    // A requested step of zero would stall a ramp forever, so it moves by one.
    function automatic logic [STEP_W-1:0] eff_step(input logic [STEP_W-1:0] stp);
        if (stp == STEP_W'(0)) begin
            return STEP_W'(1);
        end else begin
            return stp;
        end
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: counts 0..TICK_DIV-1 while run is high and flags the
// last count as a tick. clear restarts the count from zero.
module ramp_tick_gen #(
    parameter int TICK_DIV = 256,
    parameter int TICK_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_count;

    // Prescaler count: clear wins, otherwise advance and wrap only while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {TICK_W{1'b0}};
        end else if (clear) begin
            r_count <= {TICK_W{1'b0}};
        end else if (run) begin
            if (r_count == LAST) begin
                r_count <= {TICK_W{1'b0}};
            end else begin
                r_count <= r_count + TICK_W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign tick = run && !clear && (r_count == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty ramp placed between the SPI register bank's duty output and the
// PWM peripheral's duty input. With ramp_en high the delivered duty walks
// toward target_duty by at most one step per prescaler tick; with ramp_en
// low the target passes straight through on the next clock.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int TICK_DIV = 256,
    parameter int TICK_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              ramp_en,
    input  logic [STEP_W-1:0] step,
    output logic [DUTY_W-1:0] pwm_duty_cycle,
    output logic              busy,
    output logic              done
);

    pwm_state_e        r_state;
    logic [DUTY_W-1:0] r_duty;
    logic              r_busy;
    logic              r_done;

    pwm_state_e        w_state_nxt;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic              w_done_nxt;
    logic              w_busy_nxt;
    logic              w_clear;
    logic              w_run;
    logic              w_tick;
    logic [STEP_W-1:0] w_step;
    logic [DUTY_W:0]   w_up_sum;
    logic signed [DUTY_W:0] w_dn_diff;
    logic [DUTY_W-1:0] w_up_duty;
    logic [DUTY_W-1:0] w_dn_duty;
    logic [DUTY_W-1:0] w_step_duty;
    logic              w_want_up;
    logic              w_want_dn;

    assign w_run  = (r_state != IDLE);
    assign w_step = eff_step(step);

    ramp_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .run   (w_run),
        .tick  (w_tick)
    );

    // Step arithmetic is one bit wider than the duty so it can neither wrap
    // past 255 nor below 0; the result is clamped to the target.
    assign w_up_sum    = {1'b0, r_duty} + {{(DUTY_W + 1 - STEP_W){1'b0}}, w_step};
    assign w_dn_diff   = $signed({1'b0, r_duty}) - $signed({{(DUTY_W + 1 - STEP_W){1'b0}}, w_step});
    assign w_up_duty   = (w_up_sum > {1'b0, target_duty}) ? target_duty : w_up_sum[DUTY_W-1:0];
    assign w_dn_duty   = (w_dn_diff < $signed({1'b0, target_duty})) ? target_duty : w_dn_diff[DUTY_W-1:0];
    assign w_want_up   = (target_duty > r_duty);
    assign w_want_dn   = (target_duty < r_duty);
    assign w_step_duty = w_want_up ? w_up_duty : w_dn_duty;

    // Next-state, next-duty and completion decode; direction is re-judged
    // every cycle so a moving target is tracked without restarting the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_done_nxt  = 1'b0;
        w_clear     = 1'b0;
        if (!ramp_en) begin
            w_state_nxt = IDLE;
            w_duty_nxt  = target_duty;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_want_up) begin
                        w_state_nxt = RAMP_UP;
                        w_clear     = 1'b1;
                    end else if (w_want_dn) begin
                        w_state_nxt = RAMP_DOWN;
                        w_clear     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (!w_want_up && !w_want_dn) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_tick) begin
                        w_duty_nxt = w_step_duty;
                        if (w_step_duty == target_duty) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = w_want_up ? RAMP_UP : RAMP_DOWN;
                        end
                    end else begin
                        w_state_nxt = w_want_up ? RAMP_UP : RAMP_DOWN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    assign w_busy_nxt = (w_state_nxt != IDLE);

    // State and registered outputs; busy and done come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_duty  <= {DUTY_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign pwm_duty_cycle = r_duty;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
